// File: rtl/inv_sqrt_sched_pkg.sv
// Shared defaults and types for the inv_sqrt request scheduler.
package inv_sqrt_sched_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int PIPE_LAT_DEF = 36;
  localparam int DEPTH_DEF    = 64;
  localparam int ID_W         = $clog2(NREQ_DEF);

  typedef logic [ID_W-1:0] id_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO with registered empty/full flags and a flop-array head.
module sched_fifo
  import inv_sqrt_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign dout  = mem[rptr];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (do_wr) wptr <= nxt(wptr);
      if (do_rd) rptr <= nxt(rptr);
      unique case ({do_wr, do_rd})
        2'b10: begin
          cnt   <= cnt + ONE;
          empty <= 1'b0;
          full  <= (cnt == FULL_M1);
        end
        2'b01: begin
          cnt   <= cnt - ONE;
          full  <= 1'b0;
          empty <= (cnt == ONE);
        end
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/inv_sqrt_sched.sv
// Round-robin front end sharing one external inv_sqrt pipeline.
// Credits bound in-flight work so the result FIFO can never overflow.
module inv_sqrt_sched
  import inv_sqrt_sched_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               enable,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_x,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        pipe_x,
  output logic               pipe_valid_in,
  input  logic [31:0]        pipe_y,
  input  logic               pipe_valid_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_y,
  output logic [IW-1:0]      out_id,
  output logic               err_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CAP  = CW'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  if (DEPTH < PIPE_LAT + 1) begin : g_depth_chk
    $error("inv_sqrt_sched: DEPTH must be at least PIPE_LAT+1");
  end

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win;
  logic [IW-1:0]    idx;
  logic             found;
  logic             grant;
  logic             out_xfer;
  logic [CW-1:0]    credits;
  logic [31:0]      sel_x;
  logic [IW-1:0]    tag_head;
  logic             tag_empty;
  logic             tag_full;
  logic             tag_pop;
  logic             res_wr;
  logic             res_empty;
  logic             res_full;
  logic [31+IW:0]   res_din;
  logic [31+IW:0]   res_dout;

  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // nrst gates grant so req_ready is low throughout reset
  assign grant = nrst && enable && found && !tag_full &&
                 (credits < CAP);
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_comb begin
    sel_x = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IW'(k)) sel_x = req_x[32*k +: 32];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr        <= '0;
      credits       <= '0;
      pipe_valid_in <= 1'b0;
      pipe_x        <= '0;
      err_overflow  <= 1'b0;
    end else begin
      pipe_valid_in <= grant;
      if (grant) begin
        pipe_x <= sel_x;
        rr_ptr <= (win == LAST) ? '0 : win + IW'(1);
      end
      unique case ({grant, out_xfer})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
      if (pipe_valid_out && (tag_empty || res_full))
        err_overflow <= 1'b1;
    end
  end

  assign tag_pop = pipe_valid_out && !tag_empty;
  assign res_wr  = tag_pop && !res_full;
  assign res_din = {pipe_y, tag_head};

  sched_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .wr    (grant),
    .din   (win),
    .rd    (tag_pop),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full)
  );

  sched_fifo #(.WIDTH(32 + IW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .wr    (res_wr),
    .din   (res_din),
    .rd    (out_xfer),
    .dout  (res_dout),
    .empty (res_empty),
    .full  (res_full)
  );

  assign out_valid       = !res_empty;
  assign {out_y, out_id} = res_dout;

endmodule

// File: tb/tb_inv_sqrt_sched.sv
// Directed bench for inv_sqrt_sched with a delay-line stand-in for inv_sqrt.
module tb_inv_sqrt_sched;
  import inv_sqrt_sched_pkg::*;

  localparam int NREQ     = 4;
  localparam int PIPE_LAT = 36;
  localparam int DEPTH    = 64;

  logic               clk = 1'b0;
  logic               nrst;
  logic               enable;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        pipe_x;
  logic               pipe_valid_in;
  logic [31:0]        pipe_y;
  logic               pipe_valid_out;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_y;
  id_t                out_id;
  logic               err_overflow;
  logic               force_pvo;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_y_q[$];
  id_t         exp_id_q[$];
  logic [31:0] ey;
  id_t         ei;

  int          obs_acc;
  logic [31:0] obs_xv;
  logic [3:0]  obs_ready;
  logic        obs_xfer;
  logic        obs_ov;
  logic        obs_pvi;
  logic [31:0] obs_px;
  logic [31:0] obs_y;
  id_t         obs_id;
  logic        obs_err;

  always #5 clk = ~clk;

  inv_sqrt_sched #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .enable         (enable),
    .req_valid      (req_valid),
    .req_x          (req_x),
    .req_ready      (req_ready),
    .pipe_x         (pipe_x),
    .pipe_valid_in  (pipe_valid_in),
    .pipe_y         (pipe_y),
    .pipe_valid_out (pipe_valid_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_y          (out_y),
    .out_id         (out_id),
    .err_overflow   (err_overflow)
  );

  // Exact answers for the two documented operands, a cheap scramble otherwise
  function automatic logic [31:0] model(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h3F000000;
      32'h41800000: return 32'h3E800000;
      default:      return x ^ 32'h5A5A5A5A;
    endcase
  endfunction

  logic [PIPE_LAT-1:0] pv;
  logic [31:0]         py [PIPE_LAT];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[PIPE_LAT-2:0], pipe_valid_in};
      py[0] <= model(pipe_x);
      for (int k = 1; k < PIPE_LAT; k++) py[k] <= py[k-1];
    end
  end

  assign pipe_valid_out = pv[PIPE_LAT-1] | force_pvo;
  assign pipe_y         = py[PIPE_LAT-1];

  task automatic set_x(input int k, input logic [31:0] v);
    req_x[32*k +: 32] = v;
  endtask

  task automatic init_x();
    for (int k = 0; k < NREQ; k++) set_x(k, 32'h10000000 + (32'(k) << 24));
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst      = 1'b0;
    req_valid = '0;
    force_pvo = 1'b0;
    out_ready = 1'b0;
    enable    = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    exp_y_q.delete();
    exp_id_q.delete();
  endtask

  // One cycle: sample just after negedge, then advance to the next negedge
  task automatic step();
    #1;
    obs_acc = -1;
    obs_xv  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        obs_acc = k;
        obs_xv  = req_x[32*k +: 32];
      end
    end
    obs_ready = req_ready;
    obs_xfer  = out_valid && out_ready;
    obs_ov    = out_valid;
    obs_pvi   = pipe_valid_in;
    obs_px    = pipe_x;
    obs_y     = out_y;
    obs_id    = out_id;
    obs_err   = err_overflow;
    @(negedge clk);
  endtask

  task automatic note_accept();
    exp_id_q.push_back(id_t'(obs_acc));
    exp_y_q.push_back(model(obs_xv));
    set_x(obs_acc, obs_xv + 32'h00000101);
  endtask

  task automatic test_reset();
    nrst      = 1'b0;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    checks++;
    if (pipe_valid_in !== 1'b0 || pipe_x !== '0) begin
      errors++;
      $display("FAIL reset_pipe got v=%b x=%h want v=0 x=0", pipe_valid_in, pipe_x);
    end
    checks++;
    if (out_valid !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got ov=%b err=%b want 0 0", out_valid, err_overflow);
    end
    @(negedge clk);
    req_valid = '0;
    nrst      = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    out_ready = 1'b1;
    set_x(2, 32'h40800000);
    req_valid = 4'b0100;
    step();
    checks++;
    if (obs_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b want 0100", obs_ready);
    end
    req_valid = '0;
    step();
    checks++;
    if (obs_pvi !== 1'b1 || obs_px !== 32'h40800000) begin
      errors++;
      $display("FAIL single_issue got v=%b x=%h want v=1 x=40800000", obs_pvi, obs_px);
    end
    step();
    checks++;
    if (obs_pvi !== 1'b0) begin
      errors++; $display("FAIL single_pvi_drop got %b want 0", obs_pvi);
    end
    lat = -1;
    for (int n = 3; n <= 80; n++) begin
      step();
      if (obs_ov) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 38) begin
      errors++; $display("FAIL single_latency got %0d want 38", lat);
    end
    checks++;
    if (obs_id !== id_t'(2) || obs_y !== 32'h3F000000) begin
      errors++;
      $display("FAIL single_result got id=%0d y=%h want id=2 y=3f000000", obs_id, obs_y);
    end
    step();
    checks++;
    if (obs_ov !== 1'b0) begin
      errors++; $display("FAIL single_drain got ov=%b want 0", obs_ov);
    end
  endtask

  task automatic test_round_robin();
    int grants, got;
    do_reset();
    out_ready = 1'b1;
    init_x();
    req_valid = '1;
    grants = 0;
    got    = 0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      if (grants == 8) req_valid = '0;
      step();
      if (obs_acc >= 0) begin
        checks++;
        if (obs_acc != grants % 4 || c != grants) begin
          errors++;
          $display("FAIL rr_grant got id %0d at cycle %0d want id %0d at cycle %0d",
                   obs_acc, c, grants % 4, grants);
        end
        note_accept();
        grants++;
      end
      if (obs_xfer) begin
        checks++;
        if (exp_y_q.size() == 0) begin
          errors++; $display("FAIL rr_order got extra beat id %0d want none", obs_id);
        end else begin
          ey = exp_y_q.pop_front();
          ei = exp_id_q.pop_front();
          if (obs_id !== ei || obs_y !== ey) begin
            errors++;
            $display("FAIL rr_order got id %0d y %h want id %0d y %h", obs_id, obs_y, ei, ey);
          end
        end
        got++;
      end
    end
    checks++;
    if (grants != 8 || got != 8) begin
      errors++; $display("FAIL rr_count got %0d/%0d want 8/8", grants, got);
    end
  endtask

  task automatic test_credit_limit();
    int acc_n, acc2;
    do_reset();
    init_x();
    req_valid = '1;
    acc_n = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (obs_acc >= 0) begin
        note_accept();
        acc_n++;
      end
    end
    checks++;
    if (acc_n != DEPTH) begin
      errors++; $display("FAIL credit_fill got %0d want %0d", acc_n, DEPTH);
    end
    checks++;
    if (obs_ready !== '0 || obs_ov !== 1'b1) begin
      errors++; $display("FAIL credit_stall got ready=%b ov=%b want 0000 1", obs_ready, obs_ov);
    end
    out_ready = 1'b1;
    acc2 = 0;
    step();
    out_ready = 1'b0;
    if (obs_acc >= 0) begin
      note_accept();
      acc2++;
    end
    checks++;
    ey = exp_y_q.pop_front();
    ei = exp_id_q.pop_front();
    if (obs_xfer !== 1'b1 || obs_id !== ei || obs_y !== ey) begin
      errors++;
      $display("FAIL credit_head got xfer=%b id %0d y %h want xfer=1 id %0d y %h",
               obs_xfer, obs_id, obs_y, ei, ey);
    end
    for (int c = 0; c < 100; c++) begin
      step();
      if (obs_acc >= 0) begin
        note_accept();
        acc2++;
      end
    end
    checks++;
    if (acc2 != 1) begin
      errors++; $display("FAIL credit_reopen got %0d want 1", acc2);
    end
    req_valid = '0;
  endtask

  task automatic test_enable_drain();
    int acc_n, got, leak;
    do_reset();
    out_ready = 1'b1;
    init_x();
    req_valid = '1;
    acc_n = 0;
    got   = 0;
    leak  = 0;
    for (int c = 0; c < 120; c++) begin
      if (acc_n == 10) enable = 1'b0;
      step();
      if (!enable && obs_ready !== '0) leak++;
      if (obs_acc >= 0) begin
        note_accept();
        acc_n++;
      end
      if (obs_xfer) begin
        checks++;
        if (exp_y_q.size() == 0) begin
          errors++; $display("FAIL drain_order got extra beat id %0d want none", obs_id);
        end else begin
          ey = exp_y_q.pop_front();
          ei = exp_id_q.pop_front();
          if (obs_id !== ei || obs_y !== ey) begin
            errors++;
            $display("FAIL drain_order got id %0d y %h want id %0d y %h", obs_id, obs_y, ei, ey);
          end
        end
        got++;
      end
    end
    checks++;
    if (acc_n != 10 || leak != 0) begin
      errors++; $display("FAIL drain_grants got %0d leak %0d want 10 leak 0", acc_n, leak);
    end
    checks++;
    if (got != 10) begin
      errors++; $display("FAIL drain_results got %0d want 10", got);
    end
    req_valid = '0;
    enable    = 1'b1;
  endtask

  task automatic test_spurious();
    int bad;
    do_reset();
    out_ready = 1'b1;
    force_pvo = 1'b1;
    step();
    force_pvo = 1'b0;
    step();
    checks++;
    if (obs_err !== 1'b1 || obs_ov !== 1'b0) begin
      errors++; $display("FAIL spurious_flag got err=%b ov=%b want 1 0", obs_err, obs_ov);
    end
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (obs_err !== 1'b1 || obs_ov !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL spurious_sticky got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int acc_n, stale, lat;
    do_reset();
    init_x();
    req_valid = '1;
    acc_n = 0;
    for (int c = 0; c < 100 && acc_n < 20; c++) begin
      step();
      if (obs_acc >= 0) acc_n++;
    end
    req_valid = '0;
    for (int c = 0; c < 45; c++) step();
    checks++;
    if (acc_n != 20 || obs_ov !== 1'b1) begin
      errors++; $display("FAIL midrst_setup got acc %0d ov=%b want 20 1", acc_n, obs_ov);
    end
    req_valid = '1;
    nrst      = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || pipe_valid_in !== 1'b0 || pipe_x !== '0) begin
      errors++;
      $display("FAIL midrst_in got ready=%b v=%b x=%h want 0000 0 0",
               req_ready, pipe_valid_in, pipe_x);
    end
    checks++;
    if (out_valid !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out got ov=%b err=%b want 0 0", out_valid, err_overflow);
    end
    @(negedge clk);
    nrst      = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (obs_ov || obs_pvi) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midrst_stale got %0d cycles want 0", stale);
    end
    set_x(1, 32'h41800000);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    checks++;
    if (obs_ready !== 4'b0010) begin
      errors++; $display("FAIL midrst_ready got %b want 0010", obs_ready);
    end
    lat = -1;
    for (int n = 1; n <= 80; n++) begin
      step();
      if (obs_ov) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 38 || obs_id !== id_t'(1) || obs_y !== 32'h3E800000) begin
      errors++;
      $display("FAIL midrst_fresh got lat %0d id %0d y %h want 38 1 3e800000",
               lat, obs_id, obs_y);
    end
  endtask

  initial begin
    nrst      = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b0;
    req_valid = '0;
    req_x     = '0;
    force_pvo = 1'b0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_limit();
    test_enable_drain();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_sqrt_sched.md
INV_SQRT_SCHED -- requirements
Module: inv_sqrt_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one inv_sqrt pipeline.
REQ-002 Parameter PIPE_LAT, 36, cycles from pipe_valid_in high to the matching pipe_valid_out high (1+8+8+11+8).
REQ-003 Parameter DEPTH, 64, result FIFO / tag FIFO entries; must satisfy DEPTH >= PIPE_LAT+1.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 nrst  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  when low, no new request is granted; in-flight work drains normally.
REQ-007 req_valid  in  NREQ  per-requester operand valid.
REQ-008 req_x  in  NREQ*32  per-requester IEEE-754 single operand, slice i = bits [32i+31:32i].
REQ-009 req_ready  out  NREQ  per-requester accept, one-hot or zero.
REQ-010 pipe_x  out  32  operand to inv_sqrt x_in, registered.
REQ-011 pipe_valid_in  out  1  to inv_sqrt valid_in, registered.
REQ-012 pipe_y  in  32  inv_sqrt y_out.
REQ-013 pipe_valid_out  in  1  inv_sqrt valid_out.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accept.
REQ-016 out_y  out  32  result, IEEE-754 single.
REQ-017 out_id  out  clog2(NREQ)  index of the requester that issued the operand.
REQ-018 err_overflow  out  1  sticky protocol-error flag.

Function
REQ-019 Handshake on every valid/ready pair: transfer when both high in the same cycle; valid, once high, holds until transfer (stability required of upstream, guaranteed on out_*).
REQ-020 Arbitration is round-robin: priority search starts at rr_ptr; after a grant to i, rr_ptr becomes (i+1) mod NREQ; rr_ptr is unchanged when no grant is made.
REQ-021 req_ready[i] is high only when i is the arbitration winner, enable=1, and credits < DEPTH; at most one bit is high.
REQ-022 Credits = operands issued but not yet consumed at out (in pipe + in result FIFO); +1 on accept, -1 on out transfer, unchanged on simultaneous accept and out transfer.
REQ-023 On accept in cycle t: pipe_x = req_x[i] and pipe_valid_in = 1 in cycle t+1; the tag i is pushed into the tag FIFO in the same edge; pipe_valid_in is 0 in any cycle following no accept.
REQ-024 Back-to-back accepts, one per cycle, are sustained while credits permit.
REQ-025 On pipe_valid_out = 1: pipe_y and the tag FIFO head are written together into the result FIFO and the tag is popped, same edge.
REQ-026 Results leave in issue order; out_valid asserts the cycle after the FIFO write; minimum accept-to-out_valid latency is PIPE_LAT+2 cycles.
REQ-027 Result FIFO write and read in the same cycle are both performed; full result FIFO cannot be written because of the credit limit.
REQ-028 pipe_valid_out with empty tag FIFO, or result FIFO write when full, sets err_overflow; the result is dropped and the flag holds until reset.
REQ-029 Counter and pointer arithmetic wraps modulo DEPTH; credits width is clog2(DEPTH+1).

Reset
REQ-030 nrst low asynchronously clears: rr_ptr=0, credits=0, both FIFOs empty, pipe_valid_in=0, pipe_x=0, out_valid=0, err_overflow=0, req_ready=0.
REQ-031 Reset mid-operation discards all in-flight work; the inv_sqrt instance is reset from the same nrst so no stale pipe_valid_out arrives.

Structure
REQ-032 Package inv_sqrt_sched_pkg holds NREQ, PIPE_LAT, DEPTH defaults and the id_t typedef (logic [clog2(NREQ)-1:0]).
REQ-033 One sub-module sched_fifo (parameterised WIDTH, DEPTH, synchronous, registered outputs, full/empty) is instantiated twice: tag FIFO (id_t) and result FIFO (32+id_t).
REQ-034 inv_sqrt is instantiated by the parent, not inside this block.

Verification
REQ-035 Single request: req 2 sends 0x40800000 (4.0) -> one out beat, out_id=2, out_y within 0.2% of 0x3F000000 (0.5), at cycle accept+38.
REQ-036 All four requesters valid continuously, out_ready=1 -> grants cycle 0,1,2,3,0,... one per cycle; out_id sequence identical to grant sequence.
REQ-037 out_ready=0 with continuous requests -> exactly 64 accepts, then req_ready=0; one out transfer re-enables exactly one accept.
REQ-038 enable dropped with 10 in flight -> no further grants, all 10 results delivered in order.
REQ-039 Spurious pipe_valid_out forced with nothing outstanding -> err_overflow=1 next cycle, out_valid stays 0.
REQ-040 nrst pulsed low with 20 outstanding -> all outputs at reset values immediately; after release, a fresh 0x41800000 (16.0) returns ~0x3E800000 (0.25).
